// File: rtl/stream_extreme_index.sv
// Serial min/max search: accepts COUNT operands over a valid/ready stream and reports
// the index and value of the smallest (mode=0) or largest (mode=1) operand.
module stream_extreme_index #(
    parameter int WIDTH = 3,
    parameter int COUNT = 4,
    parameter int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] out_val,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(COUNT - 1);
    localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W:0]   r_cnt;
    logic [IDX_W-1:0] r_best_idx;
    logic [WIDTH-1:0] r_best_val;
    logic             r_mode;

    logic             w_accept;
    logic             w_last;
    logic             w_better;
    logic             w_first;

    // Strict comparison, so an equal later operand never displaces the earlier one.
    function automatic logic is_better(input logic          find_max,
                                       input logic [WIDTH-1:0] cand,
                                       input logic [WIDTH-1:0] best);
        return find_max ? (cand > best) : (cand < best);
    endfunction

    assign w_accept = (r_state == SCAN) && in_valid && !clear;
    assign w_last   = (r_cnt == LAST_CNT);
    assign w_first  = (r_cnt == '0);
    assign w_better = is_better(r_mode, in_data, r_best_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (start) w_state_nxt = SCAN;
                SCAN: if (w_accept && w_last) w_state_nxt = DONE;
                DONE: if (out_ready) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
            r_mode     <= 1'b0;
        end else if (clear) begin
            r_cnt <= '0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_mode <= mode;
                r_cnt  <= '0;
            end
            if (w_accept) begin
                r_cnt <= r_cnt + CNT_ONE;
                if (w_first || w_better) begin
                    r_best_val <= in_data;
                    r_best_idx <= r_cnt[IDX_W-1:0];
                end
            end
        end
    end

    // Outputs are pure state decodes; the result is masked to zero outside DONE.
    assign in_ready  = (r_state == SCAN);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_idx   = out_valid ? r_best_idx : '0;
    assign out_val   = out_valid ? r_best_val : '0;

endmodule

// File: tb/tb_stream_extreme_index.sv
// Scoreboard bench for stream_extreme_index: default (3-bit, 4-operand) and
// wide (8-bit, 7-operand) instances checked against a sort-based reference model.
module tb_stream_extreme_index;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Default-parameter instance
    logic       a_start, a_mode, a_clear, a_in_valid, a_out_ready;
    logic [2:0] a_in_data;
    logic       a_in_ready, a_out_valid, a_busy;
    logic [1:0] a_out_idx;
    logic [2:0] a_out_val;

    // Wide instance
    logic       b_start, b_mode, b_clear, b_in_valid, b_out_ready;
    logic [7:0] b_in_data;
    logic       b_in_ready, b_out_valid, b_busy;
    logic [2:0] b_out_idx;
    logic [7:0] b_out_val;

    int checks = 0;
    int errors = 0;
    int qa_idx[$], qa_val[$], qb_idx[$], qb_val[$];

    stream_extreme_index u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode), .clear(a_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_out_idx),
        .out_val(a_out_val), .busy(a_busy)
    );

    stream_extreme_index #(.WIDTH(8), .COUNT(7)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
        .out_val(b_out_val), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Winner = extreme value from a sorted copy, located at its first occurrence.
    function automatic void ref_model(input bit mx, input int d[$], output int idx, output int val);
        int s[$];
        s = d;
        s.sort();
        val = mx ? s[$] : s[0];
        idx = -1;
        for (int i = 0; i < d.size(); i++)
            if (idx < 0 && d[i] == val) idx = i;
    endfunction

    // Monitors: pop on handshake, compare held results, require zeros otherwise.
    always @(negedge clk) begin
        int ei, ev;
        if (rst_n) begin
            if (a_out_valid) begin
                if (qa_idx.size() == 0) flag("a_unexpected_out_valid");
                else if (a_out_ready) begin
                    ei = qa_idx.pop_front(); ev = qa_val.pop_front();
                    chk("a_out_idx", 32'(a_out_idx), ei);
                    chk("a_out_val", 32'(a_out_val), ev);
                end else begin
                    chk("a_hold_idx", 32'(a_out_idx), qa_idx[0]);
                    chk("a_hold_val", 32'(a_out_val), qa_val[0]);
                end
            end else begin
                chk("a_idle_idx", 32'(a_out_idx), 0);
                chk("a_idle_val", 32'(a_out_val), 0);
            end
            if (b_out_valid) begin
                if (qb_idx.size() == 0) flag("b_unexpected_out_valid");
                else if (b_out_ready) begin
                    ei = qb_idx.pop_front(); ev = qb_val.pop_front();
                    chk("b_out_idx", 32'(b_out_idx), ei);
                    chk("b_out_val", 32'(b_out_val), ev);
                end else begin
                    chk("b_hold_idx", 32'(b_out_idx), qb_idx[0]);
                    chk("b_hold_val", 32'(b_out_val), qb_val[0]);
                end
            end else begin
                chk("b_idle_idx", 32'(b_out_idx), 0);
                chk("b_idle_val", 32'(b_out_val), 0);
            end
        end
    end

    task automatic a_push(input int d, input int gap);
        int n = 0;
        a_in_valid = 1'b1;
        a_in_data  = 3'(d);
        while (!a_in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!a_in_ready) flag("a_in_ready_timeout");
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_in_data  = 3'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic a_search(input bit mx, input int d[4], input int gap, input int hold,
                            input bit toggle, input bit poke_start);
        int q[$];
        int ei, ev;
        foreach (d[i]) q.push_back(d[i]);
        ref_model(mx, q, ei, ev);
        qa_idx.push_back(ei); qa_val.push_back(ev);
        a_mode = mx; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        chk("a_busy_scan", 32'(a_busy), 1);
        chk("a_in_ready_scan", 32'(a_in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("a_no_early_valid", 32'(a_out_valid), 0);
            a_push(d[i], (i == 3) ? 0 : gap);
            if (toggle) a_mode = ~a_mode;
            if (poke_start && i == 0) begin
                a_start = 1'b1; a_mode = ~mx;
                @(posedge clk); #1;
                a_start = 1'b0;
            end
        end
        chk("a_latency", 32'(a_out_valid), 1);
        repeat (hold) begin @(posedge clk); #1; end
        chk("a_valid_held", 32'(a_out_valid), 1);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        chk("a_idle_after_handshake", 32'(a_busy), 0);
        chk("a_valid_drop", 32'(a_out_valid), 0);
    endtask

    task automatic b_search(input bit mx, input int gap, input int hold);
        int q[$];
        int ei, ev, n;
        bit narrow;
        narrow = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 7; i++) q.push_back(narrow ? $urandom_range(0, 3) : $urandom_range(0, 255));
        ref_model(mx, q, ei, ev);
        qb_idx.push_back(ei); qb_val.push_back(ev);
        b_mode = mx; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 8'(q[i]);
            n = 0;
            while (!b_in_ready && n < 20) begin @(posedge clk); #1; n++; end
            if (!b_in_ready) flag("b_in_ready_timeout");
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            b_in_data  = 8'($urandom);
            b_mode     = 1'($urandom);
            if (i < 6) repeat (gap) begin @(posedge clk); #1; end
        end
        chk("b_latency", 32'(b_out_valid), 1);
        repeat (hold) begin @(posedge clk); #1; end
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        chk("b_idle_after_handshake", 32'(b_busy), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int d[4];
        rst_n = 1'b0;
        {a_start, a_mode, a_clear, a_in_valid, a_out_ready} = '0;
        {b_start, b_mode, b_clear, b_in_valid, b_out_ready} = '0;
        a_in_data = '0;
        b_in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_in_ready", 32'(a_in_ready), 0);
        chk("rst_a_out_valid", 32'(a_out_valid), 0);
        chk("rst_a_busy", 32'(a_busy), 0);
        chk("rst_b_busy", 32'(b_busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed: min, max with mode toggling, ties, flow control
        d = '{7, 3, 2, 1}; a_search(1'b0, d, 0, 0, 1'b0, 1'b0);
        d = '{4, 1, 0, 3}; a_search(1'b1, d, 0, 0, 1'b1, 1'b0);
        d = '{0, 0, 0, 0}; a_search(1'b0, d, 0, 0, 1'b0, 1'b0);
        d = '{6, 7, 5, 7}; a_search(1'b1, d, 0, 0, 1'b0, 1'b0);
        d = '{5, 2, 6, 2}; a_search(1'b0, d, 2, 3, 1'b0, 1'b0);

        // Abort after two accepts; clear beats a pending accept
        a_mode = 1'b0; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_push(3, 0);
        a_push(2, 0);
        a_clear = 1'b1; a_in_valid = 1'b1; a_in_data = 3'd0;
        @(posedge clk); #1;
        a_clear = 1'b0; a_in_valid = 1'b0;
        chk("clear_busy", 32'(a_busy), 0);
        chk("clear_in_ready", 32'(a_in_ready), 0);
        chk("clear_out_valid", 32'(a_out_valid), 0);
        repeat (3) begin @(posedge clk); #1; end
        d = '{5, 1, 7, 4}; a_search(1'b0, d, 0, 0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a scan
        a_mode = 1'b1; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_push(7, 0);
        a_push(6, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(a_in_ready), 0);
        chk("arst_out_valid", 32'(a_out_valid), 0);
        chk("arst_busy", 32'(a_busy), 0);
        chk("arst_out_idx", 32'(a_out_idx), 0);
        chk("arst_out_val", 32'(a_out_val), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Random searches on both instances
        for (int t = 0; t < 20; t++) begin
            foreach (d[i]) d[i] = $urandom_range(0, 7);
            a_search(1'($urandom), d, $urandom_range(0, 2), $urandom_range(0, 3),
                     1'($urandom), 1'b0);
        end
        for (int t = 0; t < 30; t++)
            b_search(1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));

        repeat (2) @(posedge clk);
        #1;
        chk("a_scoreboard_drained", qa_idx.size(), 0);
        chk("b_scoreboard_drained", qb_idx.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
